// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write channel,
// plus a 32-entry pending-write scoreboard for decode-stage RAW hazard stalls.
module regfile_wb_arbiter #(
  parameter int N_REQ = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [5*N_REQ-1:0]    req_addr,
  input  logic [32*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  wr_ena,
  output logic [4:0]            wr_addr,
  output logic [31:0]           wr_data,
  input  logic                  rsv_ena,
  input  logic [4:0]            rsv_addr,
  input  logic [4:0]            rd_addr0,
  input  logic [4:0]            rd_addr1,
  output logic                  rd_hazard0,
  output logic                  rd_hazard1,
  output logic [31:0]           pending
);

  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0] r_ptr;
  logic [31:0]   r_pending;

  logic          w_found;
  logic          w_hs;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_gidx;
  logic [4:0]    w_gaddr;
  logic [31:0]   w_gdata;
  logic [31:0]   w_pending_nxt;

  // Search from r_ptr upward, wrapping; the first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < unsigned'(N_REQ); i++) begin
      w_idx = PW'((32'(r_ptr) + i) % unsigned'(N_REQ));
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = w_idx;
      end
    end
    w_hs      = w_found & ~rst;
    req_ready = '0;
    if (w_hs) req_ready[w_gidx] = 1'b1;
  end

  assign w_gaddr = req_addr[5*w_gidx +: 5];
  assign w_gdata = req_data[32*w_gidx +: 32];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      wr_ena  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (w_hs) begin
      r_ptr   <= (w_gidx == PW'(N_REQ-1)) ? '0 : w_gidx + 1'b1;
      wr_ena  <= (w_gaddr != '0);
      wr_addr <= w_gaddr;
      wr_data <= w_gdata;
    end else begin
      wr_ena  <= 1'b0;
    end
  end

  // Clear is applied before set so a same-edge reservation of the register
  // being written back leaves it pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (wr_ena) w_pending_nxt[wr_addr] = 1'b0;
    if (rsv_ena && rsv_addr != '0) w_pending_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else     r_pending <= w_pending_nxt;
  end

  assign pending    = r_pending;
  assign rd_hazard0 = r_pending[rd_addr0];
  assign rd_hazard1 = r_pending[rd_addr1];

endmodule
